// File: rtl/alu_result_uart_tx.sv
// rtl/alu_result_uart_tx.sv - serialises ALU result and flags as two back-to-back 8N1 UART frames
module alu_result_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] result,
   input  logic [3:0] flags,
   output logic       tx,
   output logic       busy,
   output logic       done
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

   state_t        state, state_n;
   logic          frame, frame_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic [3:0]    flag_reg, flag_reg_n;
   logic          tx_n, busy_n, done_n;
   logic          bit_end;

   assign bit_end = (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         frame    <= 1'b0;
         bit_idx  <= '0;
         cnt      <= '0;
         shreg    <= '0;
         flag_reg <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         frame    <= frame_n;
         bit_idx  <= bit_idx_n;
         cnt      <= cnt_n;
         shreg    <= shreg_n;
         flag_reg <= flag_reg_n;
         tx       <= tx_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

   // tx is computed one cycle ahead so the line comes straight from a flop
   always_comb begin
      state_n    = state;
      frame_n    = frame;
      bit_idx_n  = bit_idx;
      cnt_n      = cnt;
      shreg_n    = shreg;
      flag_reg_n = flag_reg;
      tx_n       = tx;
      busy_n     = busy;
      done_n     = 1'b0;
      case (state)
         IDLE: begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (start) begin
               shreg_n    = result;
               flag_reg_n = flags;
               frame_n    = 1'b0;
               cnt_n      = '0;
               state_n    = START_BIT;
               tx_n       = 1'b0;
               busy_n     = 1'b1;
            end
         end
         START_BIT: begin
            if (bit_end) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               state_n   = DATA_BITS;
               tx_n      = shreg[0];
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA_BITS: begin
            if (bit_end) begin
               cnt_n = '0;
               if (bit_idx == 3'd7) begin
                  state_n = STOP_BIT;
                  tx_n    = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + 1'b1;
                  shreg_n   = {1'b0, shreg[7:1]};
                  tx_n      = shreg[1];
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP_BIT: begin
            if (bit_end) begin
               cnt_n = '0;
               if (!frame) begin
                  // 4'hA marks the flag byte so it can't be confused with a result byte
                  shreg_n = {4'hA, flag_reg};
                  frame_n = 1'b1;
                  state_n = START_BIT;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  tx_n    = 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: doc/alu_result_uart_tx.md
# alu_result_uart_tx

Serialises the ALU result and its status flags onto a single UART line so the 8-bit datapath can be observed off-chip with one pin. It sits directly downstream of the ALU: it captures the 8-bit result and the 4 flag bits on a start request, then transmits two 8N1 frames back to back. The frames are the result byte, then a marked flag byte. The block is fully synchronous to the design clock, and all outputs are registered.

## Interface

- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range is 2 to 65535. The baud counter is sized `$clog2(CLKS_PER_BIT)` bits.
- `clk` input, 1 bit: design clock. All state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `start` input, 1 bit: transmit request. Level-sampled, and only acted on in IDLE.
- `result` input, 8 bits: ALU result R.
- `flags` input, 4 bits: {Overflow, Carry, Negative, Zero}.
- `tx` output, 1 bit: UART line. Idles high.
- `busy` output, 1 bit: high while a transmission is in progress.
- `done` output, 1 bit: one-cycle pulse when the final stop bit completes.

## Operation

- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- Other state:
  - 1-bit frame index (0 = result frame, 1 = flag frame).
  - 3-bit bit index.
  - Baud counter.
  - 8-bit shift register.
  - 4-bit flag capture register.
- IDLE behaviour:
  - `tx`=1, `busy`=0.
  - When `start`=1 is sampled, the block captures `result` into the shift register and `flags` into the flag register.
  - It then clears the frame index and enters START_BIT.
- START_BIT: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA_BITS.
- DATA_BITS:
  - `tx` = shift register bit 0, LSB first.
  - After each `CLKS_PER_BIT` cycles the register shifts right by one.
  - After 8 bits the FSM goes to STOP_BIT.
- STOP_BIT: `tx`=1 for `CLKS_PER_BIT` cycles. At the end:
  - If the frame index is 0: load the shift register with the flag byte {4'hA, flags}, set the frame index to 1, and go straight to START_BIT with no idle gap.
  - If the frame index is 1: go to IDLE, pulse `done`, and drop `busy`.
- The upper nibble 4'hA is a fixed sync marker that distinguishes the flag byte from the result byte on the wire.
- Inputs are captured once, at acceptance. Changes on `result`, `flags` or `start` while `busy`=1 are ignored. A request made while busy is never queued.
- `tx` is driven from a register, so there are no glitches.
- Asynchronous reset, including mid-frame, immediately forces:
  - State IDLE.
  - `tx`=1, `busy`=0, `done`=0.
  - All counters and registers to 0.
  - No partial frame resumes after reset.

## Timing

- Let C = `CLKS_PER_BIT`, and let k be the rising edge at which `start`=1 is sampled in IDLE.
- Edge k: `tx` goes to 0 and `busy` goes to 1. Both are visible in the cycle after the edge.
- Frame 0:
  - Data bit i (i = 0..7) drives `tx` from edge k+C·(1+i) to edge k+C·(2+i).
  - Stop bit runs from k+9C to k+10C.
- Frame 1: its start bit begins at edge k+10C, and its stop bit ends at edge k+20C.
- Edge k+20C: `busy` goes to 0, `done` goes to 1, `tx` stays 1.
- Edge k+20C+1: `done` goes to 0.
- Transaction length: `busy` is high for exactly 20·C cycles, and `done` is high for exactly 1 cycle.
- Back-to-back requests:
  - The earliest next acceptance is edge k+20C+1, when `start` is held high continuously.
  - The line therefore idles high for at least 1 cycle between transactions.
  - `done` and the next acceptance may coincide on edge k+20C+1, because `done` falls on the same edge.
- Reset values: `tx`=1, `busy`=0, `done`=0.

## Test plan

Use C=4 throughout.

1. **Basic transfer.** Drive `result`=8'h3C, `flags`=4'b0101, pulse `start` for 1 cycle.
   - `tx` sequence, sampled mid-bit: 0, 0,0,1,1,1,1,0,0, 1, then 0, 1,0,1,0,0,1,0,1, 1. The flag byte is 0xA5.
   - `busy` is high for exactly 80 cycles.
   - `done` pulses once, at edge k+80.
2. **Input isolation.** Start with `result`=8'hFF, `flags`=0. Change `result` to 8'h00 and `flags` to 4'hF at cycle k+5, and pulse `start` again at k+30.
   - The transmitted bytes remain 0xFF then 0xA0.
   - The second pulse is ignored, with no second transaction.
3. **Continuous start.** Hold `start`=1 for 200 cycles.
   - Transactions are accepted at k, k+81 and k+162.
   - `tx` is high for exactly 1 cycle between each transaction.
   - `done` pulses at k+80 and k+161.
4. **Reset mid-frame.** Assert `rst_n`=0 at cycle k+23 during a data bit of frame 0.
   - `tx`=1, `busy`=0 and `done`=0 immediately, without waiting for a clock edge.
   - After release, `tx` stays 1 until a new `start`.
   - A new request then produces a full, correct 80-cycle transfer.
5. **Minimum divider.** Set C=2 with `result`=8'h80 and `flags`=4'b1000.
   - Frame 0 has its only '1' data bit at bit 7, from k+16 to k+18.
   - The flag byte is 0xA8.
   - `busy` is high for exactly 40 cycles.
